// File: rtl/exec_seq_pkg.sv
// Shared types for the execution sequencer: the sequencer state encoding
// and a helper that classifies states as busy or idle.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        DUMP_RD  = 3'd3,
        DUMP_OUT = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    function automatic logic state_is_busy(input seq_state_t s);
        return !((s == IDLE) || (s == DONE));
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Bus bundle around the sequencer: host load stream, host dump stream,
// the core's data port and the data memory port.
interface exec_sequencer_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     load_valid;
    logic [DATA_WIDTH-1:0]    load_data;
    logic                     load_last;
    logic                     load_ready;

    logic [ADDRESS_WIDTH-1:0] cpu_mem_addr;
    logic [DATA_WIDTH-1:0]    cpu_mem_wdata;
    logic                     cpu_mem_we;
    logic [DATA_WIDTH-1:0]    cpu_mem_rdata;

    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    logic                     dump_valid;
    logic [DATA_WIDTH-1:0]    dump_data;
    logic [ADDRESS_WIDTH-1:0] dump_addr;
    logic                     dump_ready;

    // master is the sequencer; slave is the surrounding host, core and memory
    modport master (
        input  load_valid, load_data, load_last,
        output load_ready,
        input  cpu_mem_addr, cpu_mem_wdata, cpu_mem_we,
        output cpu_mem_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output dump_valid, dump_data, dump_addr,
        input  dump_ready
    );

    modport slave (
        output load_valid, load_data, load_last,
        input  load_ready,
        output cpu_mem_addr, cpu_mem_wdata, cpu_mem_we,
        input  cpu_mem_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  dump_valid, dump_data, dump_addr,
        output dump_ready
    );

endinterface

// File: rtl/mem_port_mux.sv
// Data memory port select: the core owns the port while it runs, otherwise
// the sequencer does. Core writes never leak through while it is deselected.
module mem_port_mux #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     sel_core,
    input  logic [ADDRESS_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]    core_wdata,
    input  logic                     core_we,
    input  logic [ADDRESS_WIDTH-1:0] seq_addr,
    input  logic [DATA_WIDTH-1:0]    seq_wdata,
    input  logic                     seq_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     mem_we
);

    always_comb begin
        mem_addr  = seq_addr;
        mem_wdata = seq_wdata;
        mem_we    = seq_we;
        if (sel_core) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Run controller: loads data memory from the host, runs the core until halt
// or budget expiry, then streams every memory word back to the host.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter int CNT_WIDTH     = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cycle_limit,
    input  logic                 cpu_halt,
    output logic                 cpu_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    exec_sequencer_if.master     bus
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);

    seq_state_t               state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
    logic [CNT_WIDTH-1:0]     run_cnt_reg, run_cnt_next;
    logic [CNT_WIDTH-1:0]     limit_reg, limit_next;
    logic                     timeout_reg, timeout_next;
    logic [DATA_WIDTH-1:0]    dump_data_reg, dump_data_next;
    logic [ADDRESS_WIDTH-1:0] dump_addr_reg, dump_addr_next;

    logic                     seq_we;
    logic [DATA_WIDTH-1:0]    seq_wdata;
    logic                     load_ready_c;
    logic                     dump_valid_c;
    logic [ADDRESS_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0]    mux_wdata;
    logic                     mux_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            run_cnt_reg   <= '0;
            limit_reg     <= '0;
            timeout_reg   <= 1'b0;
            dump_data_reg <= '0;
            dump_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            run_cnt_reg   <= run_cnt_next;
            limit_reg     <= limit_next;
            timeout_reg   <= timeout_next;
            dump_data_reg <= dump_data_next;
            dump_addr_reg <= dump_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        run_cnt_next   = run_cnt_reg;
        limit_next     = limit_reg;
        timeout_next   = timeout_reg;
        dump_data_next = dump_data_reg;
        dump_addr_next = dump_addr_reg;
        seq_we         = 1'b0;
        seq_wdata      = '0;
        load_ready_c   = 1'b0;
        dump_valid_c   = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = LOAD;
                    addr_next    = '0;
                    run_cnt_next = '0;
                    timeout_next = 1'b0;
                    limit_next   = cycle_limit;
                end
            end
            LOAD: begin
                load_ready_c = 1'b1;
                if (bus.load_valid) begin
                    seq_we    = 1'b1;
                    seq_wdata = bus.load_data;
                    // Address restarts at zero so the dump begins at word 0
                    if (bus.load_last || (addr_reg == LAST_ADDR)) begin
                        state_next = RUN;
                        addr_next  = '0;
                    end else begin
                        addr_next = addr_reg + ADDR_ONE;
                    end
                end
            end
            RUN: begin
                run_cnt_next = run_cnt_reg + CNT_ONE;
                if (cpu_halt) begin
                    state_next = DUMP_RD;
                end else if ((limit_reg != '0) && (run_cnt_reg == limit_reg - CNT_ONE)) begin
                    state_next   = DUMP_RD;
                    timeout_next = 1'b1;
                end
            end
            DUMP_RD: begin
                dump_data_next = bus.mem_rdata;
                dump_addr_next = addr_reg;
                state_next     = DUMP_OUT;
            end
            DUMP_OUT: begin
                dump_valid_c = 1'b1;
                if (bus.dump_ready) begin
                    if (addr_reg == LAST_ADDR) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr_reg + ADDR_ONE;
                        state_next = DUMP_RD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mem_port_mux #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_mem_port_mux (
        .sel_core   (state_reg == RUN),
        .core_addr  (bus.cpu_mem_addr),
        .core_wdata (bus.cpu_mem_wdata),
        .core_we    (bus.cpu_mem_we),
        .seq_addr   (addr_reg),
        .seq_wdata  (seq_wdata),
        .seq_we     (seq_we),
        .mem_addr   (mux_addr),
        .mem_wdata  (mux_wdata),
        .mem_we     (mux_we)
    );

    assign bus.mem_addr      = mux_addr;
    assign bus.mem_wdata     = mux_wdata;
    assign bus.mem_we        = mux_we;
    assign bus.cpu_mem_rdata = bus.mem_rdata;
    assign bus.load_ready    = load_ready_c;
    assign bus.dump_valid    = dump_valid_c;
    assign bus.dump_data     = dump_data_reg;
    assign bus.dump_addr     = dump_addr_reg;

    assign cpu_rst = (state_reg == RUN);
    assign busy    = state_is_busy(state_reg);
    assign done    = (state_reg == DONE);
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural data memory, a tiny
// core model and a scoreboard of expected memory contents.
module tb_exec_sequencer;

    localparam int DW = 20;
    localparam int AW = 8;
    localparam int CW = 24;
    localparam int MS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] cycle_limit;
    logic          cpu_halt;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          timeout;

    exec_sequencer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    exec_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MEM_SIZE      (MS),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cycle_limit (cycle_limit),
        .cpu_halt    (cpu_halt),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Data memory model with combinational read
    logic [DW-1:0] mem_model [MS];
    bit            mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < MS; i++) mem_model[i] <= DW'(32'hA0000 + i);
            mem_inited <= 1'b1;
        end else if (bus.mem_we) begin
            mem_model[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem_model[bus.mem_addr];

    // Core model: counts its own cycles out of reset, halts and writes on request
    int            core_cnt = 0;
    int            halt_at  = 0;
    int            write_at = -1;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          stray_we;
    always @(posedge clk) core_cnt <= cpu_rst ? core_cnt + 1 : 0;
    assign cpu_halt          = cpu_rst && (halt_at > 0) && (core_cnt == halt_at - 1);
    assign bus.cpu_mem_we    = stray_we || (cpu_rst && (write_at >= 0) && (core_cnt == write_at));
    assign bus.cpu_mem_addr  = core_addr;
    assign bus.cpu_mem_wdata = core_wdata;

    logic [DW-1:0] exp_mem [MS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        n_vec++;
        if ({busy, done, timeout, cpu_rst, bus.load_ready, bus.dump_valid, bus.mem_we} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy/done/to/cpu_rst/lrdy/dval/we=%b want 0000000",
                     {busy, done, timeout, cpu_rst, bus.load_ready, bus.dump_valid, bus.mem_we});
        end
        n_vec++;
        if ({bus.dump_data, bus.dump_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_dump_regs: got data=%h addr=%h want 0/0", bus.dump_data, bus.dump_addr);
        end
    endtask

    // One full start/load/run/dump sequence with optional stall, noise or abort
    task automatic run_seq(input string name, input int n_load, input bit use_last,
                           input logic [DW-1:0] base, input logic [CW-1:0] limit,
                           input int h_at, input int w_at, input int exp_cycles,
                           input bit exp_to, input int stall_word, input int stall_cycles,
                           input int abort_run, input int abort_dump, input bit noise);
        int cyc;
        int guard;
        logic [AW-1:0] w_addr;
        halt_at  = h_at;
        write_at = w_at;
        cycle_limit = limit;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycle_limit = 24'd2;
        n_vec++;
        if (!(busy === 1'b1 && bus.load_ready === 1'b1 && timeout === 1'b0 && done === 1'b0)) begin
            n_err++;
            $display("FAIL %s start: got busy=%b lrdy=%b to=%b done=%b want 1 1 0 0",
                     name, busy, bus.load_ready, timeout, done);
        end
        for (int i = 0; i < n_load; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = base + DW'(i);
            bus.load_last  = use_last && (i == n_load - 1);
            stray_we = noise;
            start    = noise;
            tick();
            exp_mem[i] = base + DW'(i);
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        stray_we = 1'b0;
        start    = 1'b0;
        n_vec++;
        if (cpu_rst !== 1'b1) begin
            n_err++;
            $display("FAIL %s run_entry: got cpu_rst=%b want 1", name, cpu_rst);
        end
        if (abort_run >= 0) begin
            repeat (abort_run) tick();
            rst = 1'b0;
            tick();
            rst = 1'b1;
            n_vec++;
            if ({busy, done, timeout, cpu_rst, bus.dump_valid, bus.load_ready, bus.mem_we} !== 7'b0) begin
                n_err++;
                $display("FAIL %s abort_run: got ctrl=%b want 0000000", name,
                         {busy, done, timeout, cpu_rst, bus.dump_valid, bus.load_ready, bus.mem_we});
            end
            return;
        end
        cyc = 0;
        while (cpu_rst === 1'b1 && cyc < 2000) begin
            cyc++;
            tick();
        end
        n_vec++;
        if (cyc != exp_cycles) begin
            n_err++;
            $display("FAIL %s run_length: got %0d cycles want %0d", name, cyc, exp_cycles);
        end
        if (w_at >= 0 && w_at < exp_cycles) exp_mem[core_addr] = core_wdata;
        n_vec++;
        if (timeout !== exp_to) begin
            n_err++;
            $display("FAIL %s timeout: got %b want %b", name, timeout, exp_to);
        end
        for (int w = 0; w < MS; w++) begin
            w_addr = AW'(w);
            guard = 0;
            while (bus.dump_valid !== 1'b1 && guard < 4) begin
                guard++;
                tick();
            end
            if (bus.dump_valid !== 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL %s dump_valid_wait: word %0d got valid=%b want 1", name, w, bus.dump_valid);
                bus.dump_ready = 1'b0;
                return;
            end
            if (w == abort_dump) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
                n_vec++;
                if ({busy, done, timeout, cpu_rst, bus.dump_valid, bus.dump_data, bus.dump_addr} !== '0) begin
                    n_err++;
                    $display("FAIL %s abort_dump: got busy=%b dval=%b data=%h addr=%h want all 0",
                             name, busy, bus.dump_valid, bus.dump_data, bus.dump_addr);
                end
                return;
            end
            if (w == stall_word) begin
                repeat (stall_cycles) begin
                    n_vec++;
                    if (bus.dump_addr !== w_addr || bus.dump_data !== exp_mem[w] ||
                        bus.dump_valid !== 1'b1 || cpu_rst !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s stall: got addr=%h data=%h v=%b cpu_rst=%b want addr=%h data=%h v=1 cpu_rst=0",
                                 name, bus.dump_addr, bus.dump_data, bus.dump_valid, cpu_rst, w_addr, exp_mem[w]);
                    end
                    tick();
                end
            end
            n_vec++;
            if (bus.dump_addr !== w_addr || bus.dump_data !== exp_mem[w]) begin
                n_err++;
                $display("FAIL %s dump_word: got addr=%h data=%h want addr=%h data=%h",
                         name, bus.dump_addr, bus.dump_data, w_addr, exp_mem[w]);
            end
            bus.dump_ready = 1'b1;
            tick();
            bus.dump_ready = 1'b0;
        end
        n_vec++;
        if (!(done === 1'b1 && busy === 1'b0 && cpu_rst === 1'b0 && bus.dump_valid === 1'b0)) begin
            n_err++;
            $display("FAIL %s finish: got done=%b busy=%b cpu_rst=%b dval=%b want 1 0 0 0",
                     name, done, busy, cpu_rst, bus.dump_valid);
        end
        $display("%s: sequence complete, run %0d cycles, timeout=%b", name, cyc, timeout);
    endtask

    task automatic test_full_load();
        core_addr = 8'h80; core_wdata = 20'h5A5A5;
        run_seq("full_load", 256, 1'b0, 20'h00000, 24'd0, 10, 9, 10, 1'b0, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_short_load();
        core_addr = 8'h40; core_wdata = 20'hDEAD0;
        run_seq("short_load", 3, 1'b1, 20'h30000, 24'd0, 2, -1, 2, 1'b0, -1, 0, -1, -1, 1'b1);
    endtask

    task automatic test_budget();
        core_addr = 8'h90; core_wdata = 20'h12345;
        run_seq("budget", 4, 1'b1, 20'h40000, 24'd5, 0, 4, 5, 1'b1, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_halt_beats_budget();
        run_seq("halt_vs_budget", 5, 1'b1, 20'h50000, 24'd4, 4, -1, 4, 1'b0, -1, 0, -1, -1, 1'b0);
    endtask

    task automatic test_dump_stall();
        run_seq("dump_stall", 10, 1'b1, 20'h60000, 24'd0, 3, -1, 3, 1'b0, 7, 20, -1, -1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        bus.load_valid = 1'b1;
        bus.load_data  = 20'hFFFFF;
        stray_we  = 1'b1;
        core_addr = 8'h10;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (bus.mem_we !== 1'b0 || bus.load_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ignored_inputs: got mem_we=%b load_ready=%b want 0 0", bus.mem_we, bus.load_ready);
            end
            tick();
        end
        bus.load_valid = 1'b0;
        stray_we = 1'b0;
        $display("ignored_inputs: 3 idle cycles with stray load/core writes");
    endtask

    task automatic test_abort();
        run_seq("abort_run", 4, 1'b1, 20'h70000, 24'd0, 0, -1, 0, 1'b0, -1, 0, 5, -1, 1'b0);
        run_seq("abort_dump", 4, 1'b1, 20'h71000, 24'd0, 2, -1, 2, 1'b0, -1, 0, -1, 2, 1'b0);
        run_seq("after_abort", 6, 1'b1, 20'h72000, 24'd0, 7, -1, 7, 1'b0, -1, 0, -1, -1, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cycle_limit = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.dump_ready = 1'b0;
        stray_we   = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        for (int i = 0; i < MS; i++) exp_mem[i] = DW'(32'hA0000 + i);

        test_reset();
        test_full_load();
        test_short_load();
        test_budget();
        test_halt_beats_budget();
        test_dump_stall();
        test_ignored_inputs();
        test_abort();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
